hamming_rx_capture: RTL and testbench

- Upstream stage of the 7-segment decoder in the Tang Nano 9K Hamming project.
- Captures a received Hamming(7,4) codeword from the board switches when the load pushbutton is pressed.
- Computes the syndrome and corrects any single-bit error.
- Holds the corrected 4-bit nibble on A..D (A = MSB) until the next press, plus error status for LEDs.

---
 rtl/hamming_rx_capture.sv | 149 ++++++++++++++
 tb/tb_hamming_rx_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : hamming_rx_capture
// Description : Captures a Hamming(7,4) codeword from the switches on a
//               debounced button press, computes the syndrome, corrects a
//               single-bit error and holds the data nibble plus error status.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_rx_capture #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sw_word,
  input  logic       btn_load,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       err_flag,
  output logic [2:0] err_pos,
  output logic       valid,
  output logic       busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DECODE  = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  logic             btn_s1, btn_s2;
  logic [6:0]       sw_s1, sw_s2;
  logic [CNT_W-1:0] db_cnt;
  logic             db_level, db_prev;
  logic             press;
  state_t           state;
  logic [6:0]       word;
  logic [2:0]       syn;
  logic [3:0]       data_fix;
  logic [2:0]       syn_calc;

  // Two-stage synchronizers for the asynchronous button and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_load;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_word;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: level only follows the button after a run of stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
    end else begin
      db_prev <= db_level;
      if (btn_s2 != db_level) begin
        if (db_cnt == CNT_MAX) begin
          db_level <= ~db_level;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Single-cycle pulse on the rising edge of the debounced level
  assign press = db_level & ~db_prev;

  // Syndrome {s3,s2,s1}; word[k] holds Hamming position k+1
  always_comb begin
    syn_calc    = 3'd0;
    syn_calc[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
    syn_calc[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
    syn_calc[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
  end

  // Capture/decode sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word     <= '0;
      syn      <= '0;
      data_fix <= '0;
      A        <= 1'b0;
      B        <= 1'b0;
      C        <= 1'b0;
      D        <= 1'b0;
      err_flag <= 1'b0;
      err_pos  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            word  <= sw_s2;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          syn   <= syn_calc;
          state <= DECODE;
        end
        DECODE: begin
          // Only the data positions (7,6,5,3) reach the outputs, so the
          // correction is applied to those bits alone; a parity-bit error
          // leaves the data untouched.
          data_fix <= {word[6] ^ (syn == 3'd7),
                       word[5] ^ (syn == 3'd6),
                       word[4] ^ (syn == 3'd5),
                       word[2] ^ (syn == 3'd3)};
          state    <= UPDATE;
        end
        UPDATE: begin
          {A, B, C, D} <= data_fix;
          err_pos      <= syn;
          err_flag     <= (syn != 3'd0);
          valid        <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_rx_capture
// Description : Self-checking bench for hamming_rx_capture (debounce = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_rx_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] sw_word = '0;
  logic       btn_load = 1'b0;
  logic       A, B, C, D, err_flag, valid, busy;
  logic [2:0] err_pos;
  logic [3:0] abcd;

  assign abcd = {A, B, C, D};

  hamming_rx_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_word  (sw_word),
    .btn_load (btn_load),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .err_flag (err_flag),
    .err_pos  (err_pos),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] sw;
    logic [3:0] abcd;
    logic       flag;
    logic [2:0] pos;
  } vec_t;

  vec_t vecs[6];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e, input logic exp_valid);
    check({tag, "_abcd"}, 32'(abcd), 32'(e.abcd));
    check({tag, "_flag"}, 32'(err_flag), 32'(e.flag));
    check({tag, "_pos"}, 32'(err_pos), 32'(e.pos));
    check({tag, "_valid"}, 32'(valid), 32'(exp_valid));
  endtask

  // Press the button for 10 cycles, pop the expectation when busy falls
  task automatic do_capture(input vec_t v);
    vec_t e;
    int   busy_cnt;
    bit   done;
    logic prev;
    sw_word = v.sw;
    repeat (5) @(negedge clk);
    sb_q.push_back(v);
    busy_cnt = 0;
    done     = 0;
    prev     = busy;
    for (int i = 0; i < 40; i++) begin
      btn_load = (i < 10);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (prev && !busy && !done) begin
        e = sb_q.pop_front();
        check_outputs("capture", e, 1'b1);
        done = 1;
      end
      prev = busy;
    end
    btn_load = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL capture_timeout: got no completion expected busy fall for sw=%b", v.sw);
      sb_q.delete();
    end
    check("busy_cycles", 32'(busy_cnt), 32'd3);
  endtask

  initial begin
    vec_t zero_v;
    vec_t last_v;
    int   busy_seen;
    bit   seen;

    // sw, expected ABCD, err_flag, err_pos
    vecs[0] = '{7'b1010101, 4'b1011, 1'b0, 3'd0};  // clean codeword
    vecs[1] = '{7'b1000101, 4'b1011, 1'b1, 3'd5};  // data position 5 flipped
    vecs[2] = '{7'b1010100, 4'b1011, 1'b1, 3'd1};  // parity position 1 flipped
    vecs[3] = '{7'b0110011, 4'b0110, 1'b0, 3'd0};  // clean codeword for 0110
    vecs[4] = '{7'b1000000, 4'b0000, 1'b1, 3'd7};  // position 7 flipped on zero
    vecs[5] = '{7'b0000011, 4'b0001, 1'b1, 3'd3};  // double error miscorrected
    zero_v  = '{7'b0000000, 4'b0000, 1'b0, 3'd0};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs("reset", zero_v, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);

    // Table-driven captures
    for (int k = 0; k < 6; k++) do_capture(vecs[k]);
    last_v = vecs[5];

    // Switch changes without a press must not disturb outputs
    sw_word = 7'b1111111;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("nopress_busy", 32'(busy_seen), 32'd0);
    check_outputs("nopress", last_v, 1'b1);

    // Bouncing button never settles long enough to register
    busy_seen = 0;
    for (int i = 0; i < 42; i++) begin
      btn_load = (i < 12) ? ((i % 2) == 0) : 1'b0;
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("bounce_busy", 32'(busy_seen), 32'd0);
    check_outputs("bounce", last_v, 1'b1);

    // Reset asserted while the sequencer is in DECODE
    sw_word = 7'b1111111;
    repeat (5) @(negedge clk);
    btn_load = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    btn_load = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL midreset_timeout: got busy=0 expected busy=1 within 20 cycles");
    end else begin
      @(negedge clk);  // DECODE cycle
      check("midreset_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_outputs("midreset", zero_v, 1'b0);
      check("midreset_busy", 32'(busy), 32'd0);
      busy_seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy) busy_seen++;
      end
      check("postreset_busy", 32'(busy_seen), 32'd0);
      check_outputs("postreset", zero_v, 1'b0);
    end

    // A fresh press after the reset loads normally
    do_capture('{7'b1111111, 4'b1111, 1'b0, 3'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
